// File: rtl/uart_frame_tx.sv
// UART frame transmitter: HEADER, CMD, 4-byte word (LSB first), PATTERN, [CHK], TAIL, each byte 8N1.
// Define UART_FRAME_CHK_EN to insert an XOR checksum of bytes 1..6 ahead of TAIL.
module uart_frame_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter logic [7:0]  HEADER   = 8'h5A,
    parameter logic [7:0]  TAIL     = 8'hEA
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [2:0]  baud_set,
    input  logic        frame_start,
    input  logic [7:0]  cmd,
    input  logic [31:0] word,
    input  logic [7:0]  pattern,
    output logic        uart_tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
    localparam int unsigned DIV_19200  = CLK_FREQ / 19200;
    localparam int unsigned DIV_38400  = CLK_FREQ / 38400;
    localparam int unsigned DIV_57600  = CLK_FREQ / 57600;
    localparam int unsigned DIV_115200 = CLK_FREQ / 115200;
    localparam int          DIV_W      = $clog2(DIV_9600 + 1);

`ifdef UART_FRAME_CHK_EN
    localparam int NUM_BYTES = 9;
`else
    localparam int NUM_BYTES = 8;
`endif
    localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);
    localparam logic [3:0] STOP_BIT  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_e;

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return DIV_W'(DIV_9600);
            3'd1:    return DIV_W'(DIV_19200);
            3'd2:    return DIV_W'(DIV_38400);
            3'd3:    return DIV_W'(DIV_57600);
            default: return DIV_W'(DIV_115200);
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       pattern_q, pattern_d;
    logic             tx_q, tx_d;
    logic [7:0]       tx_byte;

    // Frame/bit sequencing: the divider wraps at div_q-1, then the bit (and possibly byte) advances.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        cmd_d      = cmd_q;
        word_d     = word_q;
        pattern_d  = pattern_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_SEND;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    div_cnt_d  = '0;
                    div_d      = baud_div(baud_set);
                    cmd_d      = cmd;
                    word_d     = word;
                    pattern_d  = pattern;
                end
            end
            S_SEND: begin
                if (div_cnt_q == div_q - DIV_W'(1)) begin
                    div_cnt_d = '0;
                    if (bit_idx_q == STOP_BIT) begin
                        bit_idx_d = '0;
                        if (byte_idx_q == LAST_BYTE) begin
                            state_d = S_DONE;
                        end else begin
                            byte_idx_d = byte_idx_q + 4'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef UART_FRAME_CHK_EN
    logic [7:0] chk;
    assign chk = cmd_q ^ word_q[7:0] ^ word_q[15:8] ^ word_q[23:16] ^ word_q[31:24] ^ pattern_q;
`endif

    // Byte for the upcoming cycle; at acceptance it is always HEADER, so stale shadows never leak out.
    always_comb begin
        tx_byte = TAIL;
        case (byte_idx_d)
            4'd0:    tx_byte = HEADER;
            4'd1:    tx_byte = cmd_q;
            4'd2:    tx_byte = word_q[7:0];
            4'd3:    tx_byte = word_q[15:8];
            4'd4:    tx_byte = word_q[23:16];
            4'd5:    tx_byte = word_q[31:24];
            4'd6:    tx_byte = pattern_q;
`ifdef UART_FRAME_CHK_EN
            4'd7:    tx_byte = chk;
`endif
            default: tx_byte = TAIL;
        endcase
    end

    // The line is registered from next-state values so uart_tx is glitch-free and low one clk after acceptance.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == S_SEND) begin
            case (bit_idx_d)
                4'd0:    tx_d = 1'b0;
                STOP_BIT: tx_d = 1'b1;
                default: tx_d = tx_byte[3'(bit_idx_d - 4'd1)];
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            div_cnt_q  <= '0;
            div_q      <= '0;
            cmd_q      <= '0;
            word_q     <= '0;
            pattern_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            cmd_q      <= cmd_d;
            word_q     <= word_d;
            pattern_q  <= pattern_d;
            tx_q       <= tx_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q == S_SEND);
    assign tx_done = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a 1 MHz-configured instance (divisors 104/52/26/17/8) carries the
// frame tests; a default 50 MHz instance confirms the 434 and 5208 clk bit times.
module tb_uart_frame_tx;

`ifdef UART_FRAME_CHK_EN
    localparam int NB = 9;
    localparam logic [71:0] F1_EXP = 72'h5A_86_50_C3_00_00_AB_BE_EA;
    localparam logic [71:0] F2_EXP = 72'h5A_86_88_13_00_00_5A_47_EA;
    localparam logic [71:0] F3_EXP = 72'h5A_3C_EF_BE_AD_DE_00_1E_EA;
`else
    localparam int NB = 8;
    localparam logic [71:0] F1_EXP = 72'h5A_86_50_C3_00_00_AB_EA_00;
    localparam logic [71:0] F2_EXP = 72'h5A_86_88_13_00_00_5A_EA_00;
    localparam logic [71:0] F3_EXP = 72'h5A_3C_EF_BE_AD_DE_00_EA_00;
`endif

    logic        clk = 1'b0;
    logic        rst_n, rst50_n, frame_start, s_start;
    logic [2:0]  baud_set, s_baud;
    logic [7:0]  cmd, pattern;
    logic [31:0] word;
    logic        uart_tx, busy, tx_done, s_tx, s_busy, s_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int edge_cnt = 0;

    uart_frame_tx #(.CLK_FREQ(1_000_000)) dut (
        .sys_clk(clk), .rst_n(rst_n), .baud_set(baud_set), .frame_start(frame_start),
        .cmd(cmd), .word(word), .pattern(pattern),
        .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
    );

    uart_frame_tx dut50 (
        .sys_clk(clk), .rst_n(rst50_n), .baud_set(s_baud), .frame_start(s_start),
        .cmd(cmd), .word(word), .pattern(pattern),
        .uart_tx(s_tx), .busy(s_busy), .tx_done(s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (tx_done === 1'b1) done_cnt++;
    end

    always @(uart_tx) edge_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bench UART receiver: finds the start bit, samples each bit mid-cell, checks start/stop levels.
    task automatic rx_byte(input int div, output logic [7:0] b, output int ferr);
        int n;
        ferr = 0;
        n = 0;
        b = '0;
        while (uart_tx !== 1'b0 && n < 20 * div) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) ferr++;
        repeat (div / 2) @(negedge clk);
        if (uart_tx !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (div) @(negedge clk);
        if (uart_tx !== 1'b1) ferr++;
    endtask

    // mid: 0 none, 1 re-pulse frame_start with other data after byte 2, 2 switch baud_set to 4 after byte 1.
    task automatic run_frame(input string tag, input logic [7:0] c, input logic [31:0] w,
                             input logic [7:0] p, input logic [2:0] b, input int div,
                             input logic [71:0] exp, input int mid);
        logic [7:0] got;
        int fe, ferr_tot, t0, n, d0, bz0;
        ferr_tot = 0;
        d0 = done_cnt;
        bz0 = busy_cnt;
        @(negedge clk);
        cmd = c; word = w; pattern = p; baud_set = b; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        t0 = cyc;
        check($sformatf("%s_start_low", tag), uart_tx, 1'b0);
        check($sformatf("%s_busy", tag), busy, 1'b1);
        for (int k = 0; k < NB; k++) begin
            rx_byte(div, got, fe);
            ferr_tot += fe;
            check($sformatf("%s_byte%0d", tag, k), got, exp[71 - 8 * k -: 8]);
            if (k == 2 && mid == 1) begin
                cmd = ~c; word = ~w; pattern = ~p; frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
            if (k == 1 && mid == 2) baud_set = 3'd4;
        end
        check($sformatf("%s_framing", tag), ferr_tot, 0);
        n = 0;
        while (tx_done !== 1'b1 && n < 20 * div) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_done_seen", tag), tx_done, 1'b1);
        check($sformatf("%s_frame_len", tag), cyc - t0, NB * 10 * div);
        check($sformatf("%s_busy_in_done", tag), busy, 1'b0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check($sformatf("%s_done_start_ignored", tag), busy, 1'b0);
        check($sformatf("%s_done_width", tag), tx_done, 1'b0);
        check($sformatf("%s_idle_line", tag), uart_tx, 1'b1);
        check($sformatf("%s_done_count", tag), done_cnt - d0, 1);
        check($sformatf("%s_busy_cycles", tag), busy_cnt - bz0, NB * 10 * div);
    endtask

    initial begin
        logic [7:0] got;
        int fe, e0, d0, n;

        rst_n = 1'b0; rst50_n = 1'b0; frame_start = 1'b0; s_start = 1'b0;
        baud_set = 3'd4; s_baud = 3'd4; cmd = '0; word = '0; pattern = '0;
        #100;
        check("rst_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rst50_n = 1'b1;
        e0 = edge_cnt;
        repeat (50) @(negedge clk);
        check("idle_no_edges", edge_cnt - e0, 0);
        check("idle_tx", uart_tx, 1'b1);

        run_frame("f1", 8'h86, 32'h0000C350, 8'hAB, 3'd4, 8, F1_EXP, 0);
        run_frame("f2", 8'h86, 32'h00001388, 8'h5A, 3'd3, 17, F2_EXP, 0);
        run_frame("guard", 8'h86, 32'h0000C350, 8'hAB, 3'd4, 8, F1_EXP, 1);
        run_frame("baud0", 8'h86, 32'h0000C350, 8'hAB, 3'd0, 104, F1_EXP, 2);
        run_frame("baud7", 8'h3C, 32'hDEADBEEF, 8'h00, 3'd7, 8, F3_EXP, 0);

        // Abandon a frame while byte 3 (word[15:8] = 00) holds the line low.
        d0 = done_cnt;
        @(negedge clk);
        cmd = 8'h11; word = 32'h0; pattern = 8'h0; baud_set = 3'd4; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) rx_byte(8, got, fe);
        check("rstmid_byte2", got, 8'h00);
        repeat (16) @(negedge clk);
        check("rstmid_line_low", uart_tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tx_high", uart_tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_idle_tx", uart_tx, 1'b1);
        run_frame("after_rst", 8'h86, 32'h0000C350, 8'hAB, 3'd4, 8, F1_EXP, 0);

        // 50 MHz divisors: HEADER 5A starts with start bit + data0 low, i.e. a 2-bit low run.
        @(negedge clk);
        s_baud = 3'd4; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("s50_busy", s_busy, 1'b1);
        n = 0;
        while (s_tx === 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("s50_b4_low_run", n, 868);
        rst50_n = 1'b0;
        #1;
        check("s50_rst_tx", s_tx, 1'b1);
        @(negedge clk);
        rst50_n = 1'b1;
        s_baud = 3'd0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (s_tx === 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("s50_b0_low_run", n, 10416);
        rst50_n = 1'b0;
        #1;
        check("s50_no_done", s_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
